// File: rtl/f_fetch_pkg.sv
// f_fetch_pkg: shared types and constants for the fetch stage.
//
// Contents:
//   fetch_state_e    - fetch FSM state encoding (2 bits)
//   RESET_PC_DEFAULT - default PC loaded by reset
//   NOP_INSTR        - encoding placed in the pipeline for a squashed fetch
//   is_misaligned()  - word-alignment test on the low PC bits

package f_fetch_pkg;

  // StReq  : request for f_pc is presented to the instruction memory
  // StWait : request accepted, waiting for the read response
  // StHave : instruction for f_pc is buffered and ready to move into D
  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHave = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/f_fetch_fd_reg.sv
// f_fetch_fd_reg: F/D pipeline register.
//
// Loads pc/instr/valid (and the address-error flag when FETCH_ALIGN_CHK_EN is
// defined) when en_i is high, holds otherwise. Reset is synchronous,
// active-low, and clears every field.
//
// Ports:
//   clk_i    - clock
//   rst_ni   - synchronous active-low reset
//   en_i     - load enable (fetch advancing into D)
//   pc_i     - PC of the instruction entering D
//   instr_i  - instruction entering D
//   valid_i  - entering slot holds a real instruction
//   adel_i   - entering slot took an instruction address error (macro only)
//   pc_o     - PC of the instruction in D
//   instr_o  - instruction in D
//   valid_o  - D holds a real instruction (0 = bubble)
//   adel_o   - D instruction took an address error (macro only)
//
// Configuration macro: FETCH_ALIGN_CHK_EN adds the adel_i/adel_o field.

module f_fetch_fd_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
`ifdef FETCH_ALIGN_CHK_EN
  input  logic        adel_i,
  output logic        adel_o,
`endif
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
`ifdef FETCH_ALIGN_CHK_EN
  logic        adel_q, adel_d;
`endif

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
    adel_d  = adel_q;
`endif
    if (en_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = valid_i;
`ifdef FETCH_ALIGN_CHK_EN
      adel_d  = adel_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      adel_q  <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHK_EN
      adel_q  <= adel_d;
`endif
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign adel_o  = adel_q;
`endif

endmodule

// File: rtl/f_fetch.sv
// f_fetch: fetch stage of the 5-stage MIPS pipeline.
//
// Owns the F-stage PC and the F/D pipeline register. Fetches the instruction
// at f_pc through a request/response instruction-memory handshake, buffers it,
// and moves it into D when the hazard unit does not stall D. f_pc then loads
// nPc from the D-stage next-PC logic. f_miss tells the hazard unit that F has
// nothing to hand over yet.
//
// Parameters:
//   RESET_PC - PC value after reset
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - synchronous active-low reset
//   nPc         - next PC from the D-stage next-PC logic
//   d_stall     - hazard-unit stall for D
//   imem_req    - instruction read request valid
//   imem_addr   - request address (equal to f_pc)
//   imem_ready  - memory accepts the request this cycle
//   imem_rvalid - read data valid
//   imem_rdata  - read data
//   f_pc        - current F-stage PC
//   f_miss      - F holds no instruction for f_pc
//   f_adel      - f_pc is misaligned, F holds a nop (macro only)
//   d_adel      - D instruction took an address error (macro only)
//   d_pc        - PC of the instruction in D
//   d_instr     - instruction in D
//   d_valid     - D holds a real instruction (0 = bubble)
//
// Configuration macro: FETCH_ALIGN_CHK_EN enables the instruction-address
// alignment check and the f_adel/d_adel ports.

module f_fetch
  import f_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nPc,
  input  logic        d_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic        f_miss,
`ifdef FETCH_ALIGN_CHK_EN
  output logic        f_adel,
  output logic        d_adel,
`endif
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         advance;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ibuf_d   = ibuf_q;
    imem_req = 1'b0;
    advance  = 1'b0;

    case (state_q)
      StReq: begin
`ifdef FETCH_ALIGN_CHK_EN
        // A misaligned PC never reaches memory; F hands a nop to D instead.
        if (is_misaligned(pc_q[1:0])) begin
          ibuf_d  = NOP_INSTR;
          state_d = StHave;
        end else
`endif
        begin
          imem_req = 1'b1;
          if (imem_ready) begin
            if (imem_rvalid) begin
              // Zero-latency memory: data arrives with the accept.
              ibuf_d  = imem_rdata;
              state_d = StHave;
            end else begin
              state_d = StWait;
            end
          end
        end
      end

      StWait: begin
        if (imem_rvalid) begin
          ibuf_d  = imem_rdata;
          state_d = StHave;
        end
      end

      StHave: begin
        // nPc is only consumed here, so a redirect resolved in a frozen D
        // is still on nPc when F finally advances.
        if (!d_stall) begin
          advance = 1'b1;
          pc_d    = nPc;
          state_d = StReq;
        end
      end

      default: begin
        state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      ibuf_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
    end
  end

  assign imem_addr = pc_q;
  assign f_pc      = pc_q;
  assign f_miss    = (state_q != StHave);

`ifdef FETCH_ALIGN_CHK_EN
  // pc_q cannot change while in StHave, and a misaligned pc_q always takes
  // the direct StReq->StHave path, so this is exact without extra state.
  assign f_adel = (state_q == StHave) && is_misaligned(pc_q[1:0]);
`endif

  f_fetch_fd_reg u_fd_reg (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (advance),
    .pc_i    (pc_q),
    .instr_i (ibuf_q),
    .valid_i (1'b1),
`ifdef FETCH_ALIGN_CHK_EN
    .adel_i  (f_adel),
    .adel_o  (d_adel),
`endif
    .pc_o    (d_pc),
    .instr_o (d_instr),
    .valid_o (d_valid)
  );

endmodule

// File: tb/tb_f_fetch.sv
// tb_f_fetch: self-checking bench for f_fetch.
//
// A transaction-level model of the fetch stage and a small instruction-memory
// responder run alongside the DUT; one compare process checks every output at
// each falling edge, and directed steps pin the model with literal values.

module tb_f_fetch;

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] nPc;
  logic        d_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc;
  logic        f_miss;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_valid;
`ifdef FETCH_ALIGN_CHK_EN
  logic        f_adel;
  logic        d_adel;
`endif

  int checks = 0;
  int errors = 0;

  // Memory responder state (posedge process owns mem_cnt/pend_addr/cyc).
  int          mem_lat    = 0;
  int          mem_cnt    = 0;
  int          cyc        = 0;
  int          ready_from = 0;
  logic [31:0] pend_addr  = '0;
  logic        req_seen   = 1'b0;
  logic [31:0] addr_seen  = '0;
  logic        npc_auto   = 1'b1;

  // Fetch model (posedge process owns these).
  logic        m_init   = 1'b0;
  logic [31:0] m_fpc    = '0;
  logic [31:0] m_buf    = '0;
  logic        m_have   = 1'b0;
  logic        m_wait   = 1'b0;
  logic [31:0] m_dpc    = '0;
  logic [31:0] m_dinstr = '0;
  logic        m_dvalid = 1'b0;
  logic        m_dadel  = 1'b0;

  f_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .nPc         (nPc),
    .d_stall     (d_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .f_pc        (f_pc),
    .f_miss      (f_miss),
`ifdef FETCH_ALIGN_CHK_EN
    .f_adel      (f_adel),
    .d_adel      (d_adel),
`endif
    .d_pc        (d_pc),
    .d_instr     (d_instr),
    .d_valid     (d_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory outputs are a pure function of responder state, so they may be
  // re-driven at any falling edge after the configuration changes.
  task automatic mem_outputs();
    imem_ready = (cyc >= ready_from);
    if (mem_lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(imem_addr);
    end else begin
      imem_rvalid = (mem_cnt == 1);
      imem_rdata  = (mem_cnt == 1) ? memfn(pend_addr) : 32'hBAD0_BAD0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (npc_auto) nPc = m_fpc + 32'd4;
      mem_outputs();
      req_seen  = imem_req;
      addr_seen = imem_addr;
    end
  endtask

  // Model and memory bookkeeping at each rising edge, from pre-edge inputs.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_init   = 1'b1;
      m_fpc    = 32'h0000_3000;
      m_have   = 1'b0;
      m_wait   = 1'b0;
      m_buf    = '0;
      m_dpc    = '0;
      m_dinstr = '0;
      m_dvalid = 1'b0;
      m_dadel  = 1'b0;
      mem_cnt  = 0;
    end else begin
      if (m_init) begin
        if (m_have) begin
          if (!d_stall) begin
            m_dpc    = m_fpc;
            m_dinstr = m_buf;
            m_dvalid = 1'b1;
            m_dadel  = AlignEn && (m_fpc[1:0] != 2'b00);
            m_fpc    = nPc;
            m_have   = 1'b0;
          end
        end else if (m_wait) begin
          if (imem_rvalid) begin
            m_buf  = imem_rdata;
            m_have = 1'b1;
            m_wait = 1'b0;
          end
        end else if (AlignEn && (m_fpc[1:0] != 2'b00)) begin
          m_buf  = 32'h0;
          m_have = 1'b1;
        end else if (imem_ready) begin
          if (imem_rvalid) begin
            m_buf  = imem_rdata;
            m_have = 1'b1;
          end else begin
            m_wait = 1'b1;
          end
        end
      end
      if (req_seen && imem_ready) begin
        mem_cnt   = mem_lat;
        pend_addr = addr_seen;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic exp_req;
    @(negedge clk);
    if (m_init) begin
      exp_req = !m_have && !m_wait && !(AlignEn && (m_fpc[1:0] != 2'b00));
      check32("f_pc", f_pc, m_fpc);
      check32("f_miss", {31'b0, f_miss}, {31'b0, !m_have});
      check32("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) check32("imem_addr", imem_addr, m_fpc);
      check32("d_pc", d_pc, m_dpc);
      check32("d_instr", d_instr, m_dinstr);
      check32("d_valid", {31'b0, d_valid}, {31'b0, m_dvalid});
`ifdef FETCH_ALIGN_CHK_EN
      check32("f_adel", {31'b0, f_adel},
              {31'b0, m_have && (m_fpc[1:0] != 2'b00)});
      check32("d_adel", {31'b0, d_adel}, {31'b0, m_dadel});
`endif
    end
  end

  initial begin
    reset       = 1'b0;
    d_stall     = 1'b0;
    nPc         = '0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Reset state.
    tick(2);
    check32("rst_f_pc", f_pc, 32'h0000_3000);
    check32("rst_d_pc", d_pc, 32'h0);
    check32("rst_d_instr", d_instr, 32'h0);
    check32("rst_d_valid", {31'b0, d_valid}, 32'h0);
    check32("rst_f_miss", {31'b0, f_miss}, 32'h1);
    check32("rst_imem_req", {31'b0, imem_req}, 32'h1);
    reset = 1'b1;
    nPc   = 32'h0000_3004;

    // Zero-latency memory: one instruction every second edge.
    tick(2);
    check32("zl_d_pc0", d_pc, 32'h0000_3000);
    check32("zl_d_instr0", d_instr, 32'hC0DE_3000);
    check32("zl_d_valid", {31'b0, d_valid}, 32'h1);
    tick(2);
    check32("zl_d_pc1", d_pc, 32'h0000_3004);
    tick(2);
    check32("zl_d_pc2", d_pc, 32'h0000_3008);
    check32("zl_f_pc", f_pc, 32'h0000_300C);

    // Latency 3: four miss cycles per instruction, D and address stable.
    mem_lat = 3;
    mem_outputs();
    check32("l3_miss_req", {31'b0, f_miss}, 32'h1);
    check32("l3_addr", imem_addr, 32'h0000_300C);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check32("l3_miss", {31'b0, f_miss}, 32'h1);
      check32("l3_d_pc_hold", d_pc, 32'h0000_3008);
    end
    tick(1);
    check32("l3_have", {31'b0, f_miss}, 32'h0);
    tick(1);
    check32("l3_d_pc", d_pc, 32'h0000_300C);
    check32("l3_d_instr", d_instr, 32'hC0DE_300C);

    // Branch in D with a stall: redirect must survive the frozen cycles.
    npc_auto = 1'b0;
    nPc      = 32'h0000_3100;
    tick(4);
    check32("br_have", {31'b0, f_miss}, 32'h0);
    d_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check32("br_stall_f_pc", f_pc, 32'h0000_3010);
      check32("br_stall_d_pc", d_pc, 32'h0000_300C);
    end
    d_stall = 1'b0;
    tick(1);
    check32("br_f_pc", f_pc, 32'h0000_3100);
    check32("br_d_pc", d_pc, 32'h0000_3010);
    check32("br_d_instr", d_instr, 32'hC0DE_3010);

    // Reset while waiting on a response.
    npc_auto = 1'b1;
    tick(1);
    check32("rw_wait_req", {31'b0, imem_req}, 32'h0);
    reset = 1'b0;
    tick(1);
    check32("rw_f_pc", f_pc, 32'h0000_3000);
    check32("rw_d_valid", {31'b0, d_valid}, 32'h0);
    check32("rw_d_instr", d_instr, 32'h0);
    check32("rw_req", {31'b0, imem_req}, 32'h1);

    // imem_ready low for five edges while requesting.
    ready_from = cyc + 5;
    mem_lat    = 0;
    mem_outputs();
    reset      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check32("nr_req", {31'b0, imem_req}, 32'h1);
      check32("nr_addr", imem_addr, 32'h0000_3000);
      check32("nr_miss", {31'b0, f_miss}, 32'h1);
    end
    tick(1);
    check32("nr_have", {31'b0, f_miss}, 32'h0);

    // PC wrap at the top of the address space.
    npc_auto = 1'b0;
    nPc      = 32'hFFFF_FFFC;
    tick(1);
    check32("wr_f_pc", f_pc, 32'hFFFF_FFFC);
    check32("wr_d_pc0", d_pc, 32'h0000_3000);
    npc_auto = 1'b1;
    tick(2);
    check32("wr_f_pc0", f_pc, 32'h0);
    check32("wr_d_pc", d_pc, 32'hFFFF_FFFC);
    check32("wr_d_instr", d_instr, 32'hC0DE_FFFC);

`ifdef FETCH_ALIGN_CHK_EN
    // Misaligned PC: no request, nop into D with the address-error flag.
    tick(1);
    npc_auto = 1'b0;
    nPc      = 32'h0000_3006;
    tick(1);
    check32("al_f_pc", f_pc, 32'h0000_3006);
    check32("al_req0", {31'b0, imem_req}, 32'h0);
    check32("al_f_adel0", {31'b0, f_adel}, 32'h0);
    tick(1);
    check32("al_f_adel", {31'b0, f_adel}, 32'h1);
    check32("al_miss", {31'b0, f_miss}, 32'h0);
    check32("al_req1", {31'b0, imem_req}, 32'h0);
    nPc = 32'h0000_3008;
    tick(1);
    check32("al_d_adel", {31'b0, d_adel}, 32'h1);
    check32("al_d_instr", d_instr, 32'h0);
    check32("al_d_pc", d_pc, 32'h0000_3006);
    check32("al_f_adel_clr", {31'b0, f_adel}, 32'h0);
    npc_auto = 1'b1;
`endif

    tick(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
